// File: rtl/datapath_unit_pkg.sv
// Shared encodings for the datapath and its control unit.
// Covers ALU ops, bus sources, pointer selects, memory commands and register indices.
package datapath_unit_pkg;

  typedef enum logic [2:0] {
    ALU_NONE = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_MUL  = 3'd2,
    ALU_DIV  = 3'd3,
    ALU_MOD  = 3'd4
  } alu_op_e;

  typedef enum logic [3:0] {
    BUS_MEMOUT = 4'd0,
    BUS_AC     = 4'd1,
    BUS_ADDR   = 4'd2,
    BUS_MULR   = 4'd3,
    BUS_MV     = 4'd4,
    BUS_WV     = 4'd5,
    BUS_CID    = 4'd6,
    BUS_RP     = 4'd7,
    BUS_CP     = 4'd8
  } bus_sel_e;

  typedef enum logic [1:0] {
    PTR_GSP = 2'd0,
    PTR_RP  = 2'd1,
    PTR_CP  = 2'd2,
    PTR_STP = 2'd3
  } ptr_sel_e;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } mem_cmd_e;

  localparam int NUM_REGS = 14;
  localparam int REG_PC   = 0;
  localparam int REG_IR   = 1;
  localparam int REG_GSP  = 2;
  localparam int REG_RP   = 3;
  localparam int REG_CP   = 4;
  localparam int REG_STP  = 5;
  localparam int REG_CID  = 6;
  localparam int REG_EOPC = 7;
  localparam int REG_MC   = 8;
  localparam int REG_MV   = 9;
  localparam int REG_WV   = 10;
  localparam int REG_MULR = 11;
  localparam int REG_ADDR = 12;
  localparam int REG_AC   = 13;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: AC op bus. Division by zero suppresses the AC write and flags it.
module datapath_alu
  import datapath_unit_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          we,
  output logic          div_zero
);

  always_comb begin
    result   = '0;
    we       = 1'b0;
    div_zero = 1'b0;
    case (op)
      ALU_ADD: begin
        result = a + b;
        we     = 1'b1;
      end
      ALU_MUL: begin
        result = a * b;
        we     = 1'b1;
      end
      ALU_DIV: begin
        if (b == '0) div_zero = 1'b1;
        else begin
          result = a / b;
          we     = 1'b1;
        end
      end
      ALU_MOD: begin
        if (b == '0) div_zero = 1'b1;
        else begin
          result = a % b;
          we     = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath_unit.sv
// Datapath: 14-register file, bus mux, memory interface, ALU and status flags.
// Strobes come from a falling-edge control unit and are used directly.
module datapath_unit
  import datapath_unit_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    ALU_OP,
  input  logic [3:0]    Bus_Select,
  input  logic [1:0]    PCtrl,
  input  logic [13:0]   WRT_en,
  input  logic [13:0]   INC_en,
  input  logic [13:0]   RST_en,
  input  logic [1:0]    MEMCtrl,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_re,
  output logic [7:0]    INS,
  output logic          Z1,
  output logic          Z2,
  output logic          div_zero
);

  logic [DW-1:0] regs      [NUM_REGS];
  logic [DW-1:0] regs_next [NUM_REGS];
  logic [DW-1:0] memout;
  logic [DW-1:0] bus;
  logic [DW-1:0] ptr;
  logic [DW-1:0] alu_res;
  logic          alu_we;
  logic          alu_dz;
  logic          rd_pending;
  logic [7:0]    ir_inc;

  always_comb begin
    bus = '0;
    case (Bus_Select)
      BUS_MEMOUT: bus = memout;
      BUS_AC:     bus = regs[REG_AC];
      BUS_ADDR:   bus = regs[REG_ADDR];
      BUS_MULR:   bus = regs[REG_MULR];
      BUS_MV:     bus = regs[REG_MV];
      BUS_WV:     bus = regs[REG_WV];
      BUS_CID:    bus = regs[REG_CID];
      BUS_RP:     bus = regs[REG_RP];
      BUS_CP:     bus = regs[REG_CP];
      default:    bus = '0;
    endcase
  end

  always_comb begin
    ptr = regs[REG_GSP];
    case (PCtrl)
      PTR_GSP: ptr = regs[REG_GSP];
      PTR_RP:  ptr = regs[REG_RP];
      PTR_CP:  ptr = regs[REG_CP];
      PTR_STP: ptr = regs[REG_STP];
      default: ptr = regs[REG_GSP];
    endcase
  end

  assign mem_addr  = AW'(ptr);
  assign mem_wdata = bus;
  assign mem_re    = (MEMCtrl == MEM_READ);
  assign mem_we    = (MEMCtrl == MEM_WRITE);
  assign INS       = regs[REG_IR][7:0];

  datapath_alu #(.DW(DW)) u_alu (
    .op       (ALU_OP),
    .a        (regs[REG_AC]),
    .b        (bus),
    .result   (alu_res),
    .we       (alu_we),
    .div_zero (alu_dz)
  );

  // IR is only 8 bits wide, so its increment wraps at 256
  assign ir_inc = regs[REG_IR][7:0] + 8'd1;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_next[i] = regs[i];
      if (RST_en[i])
        regs_next[i] = '0;
      else if (i == REG_AC && alu_we)
        regs_next[i] = alu_res;
      else if (WRT_en[i])
        regs_next[i] = (i == REG_IR) ? {{(DW-8){1'b0}}, bus[7:0]} : bus;
      else if (INC_en[i])
        regs_next[i] = (i == REG_IR) ? {{(DW-8){1'b0}}, ir_inc} : regs[i] + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      memout     <= '0;
      rd_pending <= 1'b0;
      div_zero   <= 1'b0;
      Z1         <= 1'b1;
      Z2         <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= regs_next[i];
      rd_pending <= mem_re;
      if (rd_pending) memout <= mem_rdata;
      div_zero   <= alu_dz;
      Z1         <= (regs_next[REG_AC] == '0);
      Z2         <= (regs_next[REG_MC] == regs_next[REG_EOPC]);
    end
  end

endmodule

// File: tb/tb_datapath_unit.sv
// Directed bench for datapath_unit: reset, reads, priority, wrap, ALU and flags.
module tb_datapath_unit;
  import datapath_unit_pkg::*;

  localparam int DW = 16;
  localparam int AW = 16;

  logic          clk;
  logic          rst_n;
  logic [2:0]    ALU_OP;
  logic [3:0]    Bus_Select;
  logic [1:0]    PCtrl;
  logic [13:0]   WRT_en;
  logic [13:0]   INC_en;
  logic [13:0]   RST_en;
  logic [1:0]    MEMCtrl;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          mem_re;
  logic [7:0]    INS;
  logic          Z1;
  logic          Z2;
  logic          div_zero;

  int n_cmp = 0;
  int n_err = 0;

  datapath_unit #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ALU_OP     (ALU_OP),
    .Bus_Select (Bus_Select),
    .PCtrl      (PCtrl),
    .WRT_en     (WRT_en),
    .INC_en     (INC_en),
    .RST_en     (RST_en),
    .MEMCtrl    (MEMCtrl),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .mem_re     (mem_re),
    .INS        (INS),
    .Z1         (Z1),
    .Z2         (Z2),
    .div_zero   (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bus(input string tag, input logic [3:0] sel, input logic [15:0] exp);
    Bus_Select = sel;
    #1;
    chk_val(tag, {16'h0, mem_wdata}, {16'h0, exp});
  endtask

  // Gets a value into a register through a memory read and the MEMOUT bus source
  task automatic load(input int idx, input logic [15:0] v);
    MEMCtrl = MEM_READ;
    cyc();
    MEMCtrl   = MEM_IDLE;
    mem_rdata = v;
    cyc();
    Bus_Select = BUS_MEMOUT;
    WRT_en     = 14'd1 << idx;
    cyc();
    WRT_en = '0;
  endtask

  initial begin
    rst_n = 1'b0; ALU_OP = ALU_NONE; Bus_Select = BUS_AC; PCtrl = PTR_GSP;
    WRT_en = '0; INC_en = '0; RST_en = '0; MEMCtrl = MEM_IDLE; mem_rdata = '0;
    cyc();
    cyc();
    chk_val("rst_z1", Z1, 1);
    chk_val("rst_z2", Z2, 1);
    chk_val("rst_ins", INS, 0);
    chk_val("rst_dz", div_zero, 0);
    chk_val("rst_re", mem_re, 0);
    chk_val("rst_we", mem_we, 0);
    chk_bus("rst_ac", BUS_AC, 16'h0);
    chk_bus("rst_memout", BUS_MEMOUT, 16'h0);
    rst_n = 1'b1;

    // Read path
    load(REG_GSP, 16'd5);
    PCtrl = PTR_GSP;
    #1 chk_val("addr_gsp", mem_addr, 5);
    MEMCtrl = MEM_READ;
    #1 chk_val("re_high", mem_re, 1);
    cyc();
    MEMCtrl = MEM_IDLE; mem_rdata = 16'h1234;
    cyc();
    chk_bus("read_memout", BUS_MEMOUT, 16'h1234);
    Bus_Select = BUS_MEMOUT; WRT_en = 14'd1 << REG_AC;
    cyc();
    WRT_en = '0;
    chk_val("read_z1", Z1, 0);
    chk_bus("read_ac", BUS_AC, 16'h1234);
    MEMCtrl = MEM_WRITE; Bus_Select = BUS_AC;
    #1 chk_val("we_high", mem_we, 1);
    chk_val("wdata", mem_wdata, 16'h1234);
    MEMCtrl = MEM_IDLE;

    // Back-to-back reads then hold
    MEMCtrl = MEM_READ;
    cyc();
    mem_rdata = 16'h1111;
    cyc();
    MEMCtrl = MEM_IDLE; mem_rdata = 16'h2222;
    chk_bus("b2b_first", BUS_MEMOUT, 16'h1111);
    cyc();
    chk_bus("b2b_second", BUS_MEMOUT, 16'h2222);
    mem_rdata = 16'h3333;
    cyc();
    chk_bus("memout_hold", BUS_MEMOUT, 16'h2222);
    chk_bus("unused_sel", 4'hF, 16'h0);

    // Priority
    load(REG_AC, 16'd7);
    Bus_Select = BUS_MEMOUT;
    RST_en = 14'd1 << REG_AC; WRT_en = 14'd1 << REG_AC; INC_en = 14'd1 << REG_AC;
    cyc();
    RST_en = '0;
    chk_bus("prio_rst", BUS_AC, 16'h0);
    chk_val("prio_rst_z1", Z1, 1);
    Bus_Select = BUS_MEMOUT;
    cyc();
    WRT_en = '0; INC_en = '0;
    chk_bus("prio_wrt", BUS_AC, 16'd7);

    // Wrap
    load(REG_PC, 16'hFFFF);
    chk_val("pc_load", dut.regs[REG_PC], 16'hFFFF);
    INC_en = 14'd1 << REG_PC;
    cyc();
    INC_en = '0;
    chk_val("pc_wrap", dut.regs[REG_PC], 16'h0);
    chk_bus("wrap_ac_keep", BUS_AC, 16'd7);
    chk_bus("wrap_memout_keep", BUS_MEMOUT, 16'hFFFF);
    chk_val("wrap_z2", Z2, 1);
    load(REG_AC, 16'hFFFF);
    INC_en = 14'd1 << REG_AC;
    cyc();
    INC_en = '0;
    chk_bus("ac_wrap", BUS_AC, 16'h0);
    chk_val("ac_wrap_z1", Z1, 1);
    load(REG_IR, 16'hABCD);
    chk_val("ir_low", INS, 8'hCD);

    // ALU
    load(REG_AC, 16'd17);
    load(REG_WV, 16'd5);
    Bus_Select = BUS_WV; ALU_OP = ALU_DIV;
    cyc();
    ALU_OP = ALU_NONE;
    chk_bus("div", BUS_AC, 16'd3);
    chk_val("div_dz", div_zero, 0);
    load(REG_AC, 16'd17);
    Bus_Select = BUS_WV; ALU_OP = ALU_MOD;
    cyc();
    ALU_OP = ALU_NONE;
    chk_bus("mod", BUS_AC, 16'd2);
    Bus_Select = BUS_WV; ALU_OP = ALU_ADD;
    cyc();
    chk_bus("add", BUS_AC, 16'd7);
    Bus_Select = BUS_WV; ALU_OP = ALU_MUL;
    cyc();
    chk_bus("mul", BUS_AC, 16'd35);
    Bus_Select = BUS_WV; ALU_OP = ALU_ADD; WRT_en = 14'd1 << REG_AC;
    cyc();
    ALU_OP = ALU_NONE; WRT_en = '0;
    chk_bus("alu_over_wrt", BUS_AC, 16'd40);
    load(REG_AC, 16'h0100);
    load(REG_WV, 16'h0100);
    Bus_Select = BUS_WV; ALU_OP = ALU_MUL;
    cyc();
    ALU_OP = ALU_NONE;
    chk_bus("mul_trunc", BUS_AC, 16'h0);
    chk_val("mul_z1", Z1, 1);
    load(REG_AC, 16'd35);
    load(REG_WV, 16'd0);
    Bus_Select = BUS_WV; ALU_OP = ALU_DIV;
    cyc();
    ALU_OP = ALU_NONE;
    chk_val("dz_pulse", div_zero, 1);
    chk_bus("dz_ac_keep", BUS_AC, 16'd35);
    chk_val("dz_z1", Z1, 0);
    cyc();
    chk_val("dz_clear", div_zero, 0);

    // Z2
    load(REG_MC, 16'd3);
    chk_val("z2_ne", Z2, 0);
    load(REG_EOPC, 16'd3);
    chk_val("z2_eq", Z2, 1);
    RST_en = 14'd1 << REG_MC;
    cyc();
    RST_en = '0;
    chk_val("z2_mc_rst", Z2, 0);
    chk_bus("rst_local_memout", BUS_MEMOUT, 16'd3);

    // Mid-read reset
    MEMCtrl = MEM_READ;
    cyc();
    MEMCtrl = MEM_IDLE; rst_n = 1'b0; mem_rdata = 16'hBEEF;
    cyc();
    rst_n = 1'b1;
    chk_bus("midrd_memout", BUS_MEMOUT, 16'h0);
    chk_val("midrd_re", mem_re, 0);
    chk_val("midrd_z1", Z1, 1);
    chk_val("midrd_z2", Z2, 1);
    cyc();
    chk_bus("midrd_discard", BUS_MEMOUT, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
